// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared types and defaults for the RAM burst sequencer.
//   state_t        controller states (IDLE, WRITE, READ, DRAIN)
//   OP_READ/WRITE  encoding of cmd_op
//   DEF_ADDR_W     default RAM address width (depth = 2**DEF_ADDR_W)
//   DEF_DATA_W     default RAM word width
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 64;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_t;

endpackage

// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: bundles the command, write-stream, read-stream and RAM-side
// signals of ram_ctrl.
//   slave  modport: the controller itself (ram_ctrl)
//   master modport: the environment (command source, stream endpoints, RAM)
// Signals: cmd_valid/ready/op/addr/len, wr_valid/ready/data,
//          rd_valid/ready/data, done, ram_cen/wen/addr/din, ram_dout.
interface ram_ctrl_if #(
  parameter int ADDR_W = ram_ctrl_pkg::DEF_ADDR_W,
  parameter int DATA_W = ram_ctrl_pkg::DEF_DATA_W,
  parameter int LEN_W  = ADDR_W + 1
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  logic              done;

  logic              ram_cen;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready, ram_dout,
    output cmd_ready, wr_ready, rd_valid, rd_data, done,
    output ram_cen, ram_wen, ram_addr, ram_din
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready, ram_dout,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done,
    input  ram_cen, ram_wen, ram_addr, ram_din
  );

endinterface

// File: rtl/ram_rd_fifo.sv
// ram_rd_fifo: 2-entry read-data buffer between the RAM output and the
// read stream. The head word is presented from a register.
//   clk, reset_n  clock, asynchronous active-low reset (empties the FIFO)
//   push/push_data  write a word (caller guarantees space)
//   pop             remove the head word (caller guarantees count != 0)
//   head            current head word
//   count           occupancy 0..2
module ram_rd_fifo #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: storage is reset here (only two words) so rd_data reads 0 in reset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: initiator-side burst sequencer for a single-port synchronous RAM.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; aborts any burst
//   bus      ram_ctrl_if.slave: command handshake, write stream in,
//            read stream out, done pulse, RAM control/data pins
// A write beat goes straight to the RAM in the cycle it is offered. Reads
// are issued ahead into a 2-entry FIFO; read data lands one cycle after
// issue (inflight) and appears on rd_data one cycle after that.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input logic         clk,
  input logic         reset_n,
  ram_ctrl_if.slave   bus
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr, addr_next;
  logic [LEN_W-1:0]  remaining, remaining_next;
  logic              inflight, inflight_next;
  logic              done_q, done_next;

  logic [1:0]        fifo_count;
  logic              rd_valid;
  logic              pop;
  logic [2:0]        load;

  assign rd_valid = (fifo_count != 2'd0);
  assign pop      = rd_valid && bus.rd_ready;

  // Words held or on their way after this edge. A pop this cycle frees its
  // slot in time, which is what sustains one word per cycle.
  assign load = {1'b0, fifo_count} - {2'b0, pop} + {2'b0, inflight};

  ram_rd_fifo #(
    .DATA_W (DATA_W)
  ) u_rd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (bus.ram_dout),
    .pop       (pop),
    .head      (bus.rd_data),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      addr      <= addr_next;
      remaining <= remaining_next;
      inflight  <= inflight_next;
      done_q    <= done_next;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no latch is inferred.
    state_next     = state;
    addr_next      = addr;
    remaining_next = remaining;
    inflight_next  = 1'b0;
    done_next      = 1'b0;
    bus.cmd_ready  = 1'b0;
    bus.wr_ready   = 1'b0;
    bus.ram_cen    = 1'b0;
    bus.ram_wen    = 1'b0;
    bus.ram_addr   = '0;
    bus.ram_din    = '0;

    unique case (state)
      IDLE: begin
        // State already reads IDLE during reset; gate so cmd_ready is 0 then.
        bus.cmd_ready = reset_n;
        if (bus.cmd_valid && reset_n) begin
          addr_next      = bus.cmd_addr;
          remaining_next = bus.cmd_len;
          if (bus.cmd_len == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = (bus.cmd_op == OP_WRITE) ? WRITE : READ;
          end
        end
      end

      WRITE: begin
        bus.wr_ready = 1'b1;
        if (bus.wr_valid) begin
          bus.ram_cen    = 1'b1;
          bus.ram_wen    = 1'b1;
          bus.ram_addr   = addr;
          bus.ram_din    = bus.wr_data;
          addr_next      = addr + ADDR_W'(1);
          remaining_next = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end

      READ: begin
        if (load < 3'd2) begin
          bus.ram_cen    = 1'b1;
          bus.ram_addr   = addr;
          inflight_next  = 1'b1;
          addr_next      = addr + ADDR_W'(1);
          remaining_next = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state_next = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Nothing in flight and the FIFO empties at this edge.
        if (load == 3'd0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.rd_valid = rd_valid;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed, table-driven bench for ram_ctrl with a behavioural
// single-port RAM (one-cycle read latency, contents survive reset).
module tb_ram_ctrl;

  logic clk;
  logic reset_n;

  ram_ctrl_if #(.ADDR_W(8), .DATA_W(64), .LEN_W(9)) bus ();

  ram_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM
  logic [63:0] mem [256];
  always @(posedge clk) begin
    if (bus.ram_cen) begin
      if (bus.ram_wen) mem[bus.ram_addr] <= bus.ram_din;
      else             bus.ram_dout      <= mem[bus.ram_addr];
    end
  end

  // Event log, sampled late in each cycle (just before the rising edge)
  typedef struct {
    int          cyc;
    logic        wen;
    logic [7:0]  addr;
    logic [63:0] din;
    int          outst;
  } cen_ev_t;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } pop_ev_t;

  typedef struct {
    int   cyc;
    logic rdy;
  } done_ev_t;

  cen_ev_t  cen_q  [$];
  pop_ev_t  pop_q  [$];
  done_ev_t done_q [$];
  int       hs_q   [$];
  int       cyc = 0;
  int       outst = 0;
  int       idle_bus_err = 0;

  always @(negedge clk) begin
    #3;
    cyc = cyc + 1;
    if (!reset_n) begin
      outst = 0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) hs_q.push_back(cyc);
      if (bus.rd_valid && bus.rd_ready) begin
        pop_q.push_back('{cyc, bus.rd_data});
        outst = outst - 1;
      end
      if (bus.ram_cen) begin
        if (!bus.ram_wen) outst = outst + 1;
        cen_q.push_back('{cyc, bus.ram_wen, bus.ram_addr, bus.ram_din, outst});
      end
      if (bus.done) done_q.push_back('{cyc, bus.cmd_ready});
      if (!bus.ram_cen && (bus.ram_wen || bus.ram_addr != 8'd0 || bus.ram_din != 64'd0))
        idle_bus_err = idle_bus_err + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [63:0] wq [$];   // write data for the current burst
  logic [63:0] eq [$];   // expected read data for the current burst

  task automatic do_burst(input string name, input logic op, input logic [7:0] a,
                          input logic [8:0] len, input int stall_start, input int stall_len);
    int cb, pb, db, hb, beat, k, guard, ncen, npop, last_ev, maxo, span;
    @(negedge clk);
    cb = cen_q.size();
    pb = pop_q.size();
    db = done_q.size();
    hb = hs_q.size();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    #1;
    guard = 0;
    while (!bus.cmd_ready && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_addr  = 8'd0;
    bus.cmd_len   = 9'd0;

    beat = 0;
    guard = 0;
    while (op && beat < int'(len) && guard < 600) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = wq[beat];
      #1;
      if (bus.wr_ready) beat++;
      guard++;
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    bus.wr_data  = 64'd0;

    k = 0;
    while (done_q.size() == db && k < 600) begin
      bus.rd_ready = !(k >= stall_start && k < stall_start + stall_len);
      @(negedge clk);
      k++;
    end
    bus.rd_ready = 1'b1;
    repeat (3) @(negedge clk);

    ncen = cen_q.size() - cb;
    npop = pop_q.size() - pb;
    check({name, "_ncen"},  ncen, len);
    check({name, "_npop"},  npop, op ? 9'd0 : len);
    check({name, "_ndone"}, done_q.size() - db, 1);
    check({name, "_nhs"},   hs_q.size() - hb, 1);

    for (int i = 0; i < ncen && i < int'(len); i++) begin
      check({name, "_addr"}, cen_q[cb+i].addr, 8'(a + i));
      check({name, "_wen"},  cen_q[cb+i].wen, op);
      if (op) check({name, "_din"}, cen_q[cb+i].din, wq[i]);
    end
    for (int i = 0; i < npop && i < int'(len); i++)
      check({name, "_rdata"}, pop_q[pb+i].data, eq[i]);

    if (done_q.size() > db && hs_q.size() > hb) begin
      last_ev = hs_q[hb];
      if (len != 0 && op && ncen > 0)  last_ev = cen_q[cen_q.size()-1].cyc;
      if (len != 0 && !op && npop > 0) last_ev = pop_q[pop_q.size()-1].cyc;
      check({name, "_done_cycle"}, done_q[db].cyc, last_ev + 1);
      check({name, "_rdy_at_done"}, done_q[db].rdy, 1);
      if (ncen > 0) check({name, "_first_issue"}, cen_q[cb].cyc, hs_q[hb] + 1);
    end

    if (!op && ncen > 0 && npop > 0)
      check({name, "_rd_latency"}, pop_q[pb].cyc, cen_q[cb].cyc + 2);

    if (ncen == int'(len) && len > 1) begin
      span = cen_q[cen_q.size()-1].cyc - cen_q[cb].cyc;
      if (stall_len == 0) begin
        check({name, "_cen_span"}, span, len - 1);
        if (!op && npop == int'(len))
          check({name, "_pop_span"}, pop_q[pop_q.size()-1].cyc - pop_q[pb].cyc, len - 1);
      end else begin
        check({name, "_issue_stalled"}, span > int'(len) - 1, 1);
      end
    end

    if (!op && ncen > 0) begin
      maxo = 0;
      for (int i = cb; i < cen_q.size(); i++)
        if (cen_q[i].outst > maxo) maxo = cen_q[i].outst;
      check({name, "_max_outstanding_le2"}, maxo <= 2, 1);
    end
  endtask

  typedef struct {
    string       name;
    logic        op;
    logic [7:0]  addr;
    logic [8:0]  len;
    logic [63:0] wbase;
    logic [63:0] exp_base;
    int          stall_start;
    int          stall_len;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat, guard, db;

    reset_n       = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_addr  = 8'd0;
    bus.cmd_len   = 9'd0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 64'd0;
    bus.rd_ready  = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 64'hA000_0000_0000_0000 | 64'(i);

    vecs[0] = '{"wr_wrap", 1'b1, 8'hFE, 9'd4, 64'd1, 64'd0, 0, 0};
    vecs[1] = '{"rd_wrap", 1'b0, 8'hFE, 9'd4, 64'd0, 64'd1, 0, 0};
    vecs[2] = '{"rd_backpressure", 1'b0, 8'h10, 9'd5, 64'd0, 64'hA000_0000_0000_0010, 3, 6};
    vecs[3] = '{"wr_one", 1'b1, 8'h80, 9'd1, 64'h1234_5678_9ABC_DEF0, 64'd0, 0, 0};
    vecs[4] = '{"rd_one", 1'b0, 8'h80, 9'd1, 64'd0, 64'h1234_5678_9ABC_DEF0, 0, 0};
    vecs[5] = '{"wr_zero", 1'b1, 8'h33, 9'd0, 64'd0, 64'd0, 0, 0};
    vecs[6] = '{"rd_zero", 1'b0, 8'h50, 9'd0, 64'd0, 64'd0, 0, 0};
    vecs[7] = '{"rd_init", 1'b0, 8'hF0, 9'd2, 64'd0, 64'hA000_0000_0000_00F0, 0, 0};

    // Reset state
    #1 reset_n = 1'b0;
    #10;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_wr_ready",  bus.wr_ready,  0);
    check("rst_rd_valid",  bus.rd_valid,  0);
    check("rst_done",      bus.done,      0);
    check("rst_ram_cen",   bus.ram_cen,   0);
    check("rst_ram_wen",   bus.ram_wen,   0);
    check("rst_ram_addr",  bus.ram_addr,  0);
    check("rst_ram_din",   bus.ram_din,   0);
    check("rst_rd_data",   bus.rd_data,   0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("idle_cmd_ready", bus.cmd_ready, 1);
    check("idle_wr_ready",  bus.wr_ready,  0);

    // Two-beat write at 0x00
    wq = '{64'h0000_0000_0000_ffff, 64'hffff_ffff_0000_0000};
    do_burst("wr_two", 1'b1, 8'h00, 9'd2, 0, 0);

    // Read back three words, the third untouched
    eq = '{64'h0000_0000_0000_ffff, 64'hffff_ffff_0000_0000, 64'hA000_0000_0000_0002};
    do_burst("rd_three", 1'b0, 8'h00, 9'd3, 0, 0);

    // Table-driven bursts
    foreach (vecs[v]) begin
      wq.delete();
      eq.delete();
      for (int i = 0; i < int'(vecs[v].len); i++) begin
        wq.push_back(vecs[v].wbase + 64'(i));
        eq.push_back(vecs[v].exp_base + 64'(i));
      end
      do_burst(vecs[v].name, vecs[v].op, vecs[v].addr, vecs[v].len,
               vecs[v].stall_start, vecs[v].stall_len);
    end

    // Reset in the middle of an 8-beat write, after 3 beats
    @(negedge clk);
    db = done_q.size();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b1;
    bus.cmd_addr  = 8'h40;
    bus.cmd_len   = 9'd8;
    #1;
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = 9'd0;
    bus.cmd_addr  = 8'd0;
    beat = 0;
    guard = 0;
    while (beat < 3 && guard < 20) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 64'h0BAD_F00D_0000_0000 + 64'(beat);
      #1;
      if (bus.wr_ready) beat++;
      guard++;
      @(negedge clk);
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = 64'h0BAD_F00D_0000_0003;
    #2;
    check("mid_rst_cen_before", bus.ram_cen, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ram_cen",   bus.ram_cen,   0);
    check("mid_rst_ram_addr",  bus.ram_addr,  0);
    check("mid_rst_wr_ready",  bus.wr_ready,  0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 0);
    check("mid_rst_rd_valid",  bus.rd_valid,  0);
    bus.wr_valid = 1'b0;
    bus.wr_data  = 64'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    repeat (3) @(negedge clk);
    check("post_rst_no_done", done_q.size() - db, 0);

    eq = '{64'h0BAD_F00D_0000_0000, 64'h0BAD_F00D_0000_0001,
           64'h0BAD_F00D_0000_0002, 64'hA000_0000_0000_0043};
    do_burst("rd_after_rst", 1'b0, 8'h40, 9'd4, 0, 0);

    check("idle_bus_quiet", idle_bus_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
